packet_filter_buffer: RTL

Store-and-forward packet buffer placed directly downstream of packet_parser. It consumes the parser's payload stream (bus_out_* from the parser, driven here into bus_in_*) and the parsed headerA. It drops packets whose headerA does not match a programmed value, and packets that overflow the buffer or arrive truncated. Only complete, accepted packets are forwarded on a valid/ready output bus; the input side has no backpressure.

---
 rtl/packet_filter_buffer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/packet_filter_buffer.sv
// packet_filter_buffer: store-and-forward buffer that drops filtered, oversized and truncated packets.
// Optional drop counter port drop_cnt enabled by defining PKT_FILTER_DROP_CNT_EN.
module packet_filter_buffer #(
    parameter int WIDTH_DATA_BYTES  = 8,
    parameter int WIDTH_HDR_A_BYTES = 6,
    parameter int DEPTH             = 16
) (
    input  logic                           clk_host,
    input  logic                           rst_n,
    input  logic                           bus_in_valid,
    input  logic                           bus_in_sop,
    input  logic                           bus_in_eop,
    input  logic [WIDTH_DATA_BYTES-1:0]    bus_in_byteen,
    input  logic [8*WIDTH_DATA_BYTES-1:0]  bus_in_data,
    input  logic [8*WIDTH_HDR_A_BYTES-1:0] headerA,
    input  logic                           cfg_filter_en,
    input  logic [8*WIDTH_HDR_A_BYTES-1:0] cfg_match_a,
    input  logic                           bus_out_ready,
    output logic                           bus_out_valid,
    output logic                           bus_out_sop,
    output logic                           bus_out_eop,
    output logic [WIDTH_DATA_BYTES-1:0]    bus_out_byteen,
    output logic [8*WIDTH_DATA_BYTES-1:0]  bus_out_data,
    output logic [$clog2(DEPTH):0]         buf_level
`ifdef PKT_FILTER_DROP_CNT_EN
    ,
    output logic [15:0]                    drop_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 2 + WIDTH_DATA_BYTES + 8 * WIDTH_DATA_BYTES;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCEPT  = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;
    localparam logic [PW-1:0] ONE  = PW'(1);
    localparam logic [PW-1:0] FULL = PW'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [1:0]    state_q, state_d;
    logic [PW-1:0] ws_q, ws_d, wc_q, wc_d, rd_q, rd_d;
    logic [PW-1:0] base, wr_ptr;
    logic          out_valid_q, out_valid_d;
    logic [EW-1:0] out_entry_q, out_entry_d;
    logic          we, drop, mismatch, empty, load;

    assign mismatch = cfg_filter_en && (headerA != cfg_match_a);
    // A sop while accepting abandons the open packet, so the new one starts at the committed pointer.
    assign base = (state_q == S_ACCEPT) ? wc_q : ws_q;

    always_comb begin
        state_d = state_q;
        ws_d    = ws_q;
        wc_d    = wc_q;
        we      = 1'b0;
        wr_ptr  = ws_q;
        drop    = 1'b0;
        if (bus_in_valid) begin
            if (bus_in_sop) begin
                drop = (state_q == S_ACCEPT);
                ws_d = base;
                if (mismatch || (base - rd_q) == FULL) begin
                    drop    = 1'b1;
                    state_d = bus_in_eop ? S_IDLE : S_DISCARD;
                end else begin
                    we      = 1'b1;
                    wr_ptr  = base;
                    ws_d    = base + ONE;
                    wc_d    = bus_in_eop ? base + ONE : wc_q;
                    state_d = bus_in_eop ? S_IDLE : S_ACCEPT;
                end
            end else if (state_q == S_ACCEPT) begin
                if ((ws_q - rd_q) == FULL) begin
                    ws_d    = wc_q;
                    drop    = 1'b1;
                    state_d = bus_in_eop ? S_IDLE : S_DISCARD;
                end else begin
                    we      = 1'b1;
                    ws_d    = ws_q + ONE;
                    wc_d    = bus_in_eop ? ws_q + ONE : wc_q;
                    state_d = bus_in_eop ? S_IDLE : S_ACCEPT;
                end
            end else if (state_q == S_DISCARD && bus_in_eop) begin
                state_d = S_IDLE;
            end
        end
    end

    assign empty = (wc_q == rd_q);
    assign load  = (!out_valid_q || bus_out_ready) && !empty;

    always_comb begin
        rd_d        = load ? rd_q + ONE : rd_q;
        out_valid_d = load ? 1'b1 : (bus_out_ready ? 1'b0 : out_valid_q);
        out_entry_d = load ? mem_q[rd_q[AW-1:0]] : out_entry_q;
    end

    always_ff @(posedge clk_host) begin
        if (we) mem_q[wr_ptr[AW-1:0]] <= {bus_in_sop, bus_in_eop, bus_in_byteen, bus_in_data};
    end

    always_ff @(posedge clk_host or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ws_q        <= '0;
            wc_q        <= '0;
            rd_q        <= '0;
            out_valid_q <= 1'b0;
            out_entry_q <= '0;
        end else begin
            state_q     <= state_d;
            ws_q        <= ws_d;
            wc_q        <= wc_d;
            rd_q        <= rd_d;
            out_valid_q <= out_valid_d;
            out_entry_q <= out_entry_d;
        end
    end

    assign bus_out_valid = out_valid_q;
    assign {bus_out_sop, bus_out_eop, bus_out_byteen, bus_out_data} = out_entry_q;
    assign buf_level = (wc_q - rd_q) + PW'(out_valid_q);

`ifdef PKT_FILTER_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;

    always_ff @(posedge clk_host or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= '0;
        else drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`else
    logic drop_unused;
    assign drop_unused = drop;
`endif
endmodule
